// File: rtl/axi_read_responder_pkg.sv
// Shared types for the AXI-style read responder: request record, FSM states,
// channel widths and the ARLEN normalisation helper.
package axi_read_responder_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ID_WIDTH   = 4;
    localparam int LEN_WIDTH  = 8;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
        logic [ID_WIDTH-1:0]   id;
    } axi_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } resp_state_t;

    // ARLEN is a beat count; a zero length still returns one beat.
    function automatic logic [LEN_WIDTH-1:0] beat_count(input logic [LEN_WIDTH-1:0] len);
        return (len == '0) ? LEN_WIDTH'(1) : len;
    endfunction

endpackage

// File: rtl/axi_read_responder_queue.sv
// In-order FIFO of accepted read requests; push and pop may share a cycle,
// including when the FIFO is full. DEPTH must be a power of two.
module resp_queue
    import axi_read_responder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_push,
    input  axi_req_t i_din,
    input  logic     i_pop,
    output axi_req_t o_dout,
    output logic     o_full,
    output logic     o_empty
);

    localparam int PW = $clog2(DEPTH);

    axi_req_t      r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_din;
    end

endmodule

// File: rtl/axi_read_responder.sv
// Memory-side AXI read slave: queues burst requests in order, waits LATENCY
// cycles from taking a request, then streams words from a backdoor-loaded RAM.
module axi_read_responder
    import axi_read_responder_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int LATENCY        = 4,
    parameter int QUEUE_DEPTH    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     ARADDR,
    input  logic [LEN_WIDTH-1:0]      ARLEN,
    input  logic [ID_WIDTH-1:0]       ARID,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [ID_WIDTH-1:0]       RID,
    output logic                      RLAST,
    output logic                      RVALID,
    input  logic                      RREADY,
    input  logic                      i_load_we,
    input  logic [MEM_ADDR_WIDTH-1:0] i_load_addr,
    input  logic [DATA_WIDTH-1:0]     i_load_data,
    output resp_state_t               o_dbg_state
);

    // Both channels use valid/ready: a transfer happens on the rising edge where
    // valid and ready are both high; once RVALID is raised the beat is held
    // unchanged until it is accepted.

    localparam int         MEM_WORDS = 1 << MEM_ADDR_WIDTH;
    localparam logic [3:0] LAT_LOAD  = 4'(LATENCY - 1);

    logic [DATA_WIDTH-1:0]     r_mem [MEM_WORDS];
    resp_state_t               r_state;
    logic [3:0]                r_cnt;
    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]      r_remain;
    logic [ID_WIDTH-1:0]       r_id;
    logic                      r_rvalid;
    logic                      r_rlast;
    logic [ID_WIDTH-1:0]       r_rid;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic                      r_ar_en;

    axi_req_t                  w_in_req;
    axi_req_t                  w_head;
    axi_req_t                  w_next;
    logic [MEM_ADDR_WIDTH-1:0] w_next_word;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_accept;
    logic                      w_hs;
    logic                      w_need;
    logic                      w_take;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_unused;

    assign ARREADY  = r_ar_en && !w_full;
    assign w_accept = ARVALID && ARREADY;
    assign w_in_req = '{addr: ARADDR, len: ARLEN, id: ARID};
    assign w_hs     = r_rvalid && RREADY;

    // With an empty queue a freshly accepted request goes straight to the
    // engine, so the first beat lands LATENCY cycles after acceptance.
    assign w_next      = w_empty ? w_in_req : w_head;
    assign w_need      = (r_state == ST_IDLE) || (w_hs && r_rlast);
    assign w_take      = w_need && (!w_empty || w_accept);
    assign w_pop       = w_take && !w_empty;
    assign w_push      = w_accept && !(w_take && w_empty);
    assign w_next_word = w_next.addr[MEM_ADDR_WIDTH+1:2];
    assign w_unused    = ^w_next.addr;

    resp_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (w_push),
        .i_din  (w_in_req),
        .i_pop  (w_pop),
        .o_dout (w_head),
        .o_full (w_full),
        .o_empty(w_empty)
    );

    always_ff @(posedge clk) begin
        r_ar_en <= rst_n;
    end

    always_ff @(posedge clk) begin
        if (i_load_we) r_mem[i_load_addr] <= i_load_data;
    end

    // r_addr always points at the word to fetch for the next beat, so RDATA is
    // refilled on the same edge that retires the current beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_remain <= '0;
            r_id     <= '0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rid    <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_addr   <= w_next_word;
                        r_remain <= beat_count(w_next.len);
                        r_id     <= w_next.id;
                        r_cnt    <= LAT_LOAD;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_rdata  <= r_mem[r_addr];
                        r_addr   <= r_addr + 1'b1;
                        r_rid    <= r_id;
                        r_rlast  <= (r_remain == LEN_WIDTH'(1));
                        r_rvalid <= 1'b1;
                        r_state  <= ST_BURST;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_BURST: begin
                    if (w_hs) begin
                        if (r_rlast) begin
                            r_rvalid <= 1'b0;
                            r_rlast  <= 1'b0;
                            if (w_take) begin
                                r_addr   <= w_next_word;
                                r_remain <= beat_count(w_next.len);
                                r_id     <= w_next.id;
                                r_cnt    <= LAT_LOAD;
                                r_state  <= ST_WAIT;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_rdata  <= r_mem[r_addr];
                            r_addr   <= r_addr + 1'b1;
                            r_remain <= r_remain - 1'b1;
                            r_rlast  <= (r_remain == LEN_WIDTH'(2));
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign RVALID      = r_rvalid;
    assign RLAST       = r_rlast;
    assign RID         = r_rid;
    assign RDATA       = r_rdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axi_read_responder.sv
// Bench for axi_read_responder: table-driven bursts, hand-written multi-cycle
// sequences and a randomized run against a word-level reference model.
module tb_axi_read_responder;
    import axi_read_responder_pkg::*;

    localparam int MAW       = 12;
    localparam int LAT       = 4;
    localparam int MEM_WORDS = 1 << MAW;
    localparam int BW        = DATA_WIDTH + ID_WIDTH + 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [LEN_WIDTH-1:0]  ARLEN;
    logic [ID_WIDTH-1:0]   ARID;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [ID_WIDTH-1:0]   RID;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;
    logic                  i_load_we;
    logic [MAW-1:0]        i_load_addr;
    logic [DATA_WIDTH-1:0] i_load_data;
    resp_state_t           o_dbg_state;

    always #5 clk = ~clk;

    axi_read_responder #(
        .MEM_ADDR_WIDTH(MAW),
        .LATENCY       (LAT),
        .QUEUE_DEPTH   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ARADDR     (ARADDR),
        .ARLEN      (ARLEN),
        .ARID       (ARID),
        .ARVALID    (ARVALID),
        .ARREADY    (ARREADY),
        .RDATA      (RDATA),
        .RID        (RID),
        .RLAST      (RLAST),
        .RVALID     (RVALID),
        .RREADY     (RREADY),
        .i_load_we  (i_load_we),
        .i_load_addr(i_load_addr),
        .i_load_data(i_load_data),
        .o_dbg_state(o_dbg_state)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
        logic [7:0]  rr_pat;
        int          rr_n;
        int          exp_beats;
        int          exp_word;
    } vec_t;

    logic [DATA_WIDTH-1:0] model_mem [MEM_WORDS];
    logic [BW-1:0]         exp_q[$];
    axi_req_t              req_q[$];
    bit                    rr_q[$];
    int                    start_q[$];
    int                    acc_q[$];
    int                    last_hs_q[$];
    logic [ID_WIDTH-1:0]   id_q[$];
    logic [DATA_WIDTH-1:0] first_q[$];
    vec_t                  vecs[6];

    int            n_chk = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            n_hs = 0;
    int            n_valid = 0;
    int            total_beats = 0;
    bit            in_burst = 0;
    bit            stall_prev = 0;
    bit            rr_rand = 0;
    bit            ar_rand = 0;
    bit            ar_stall_seen = 0;
    logic [BW-1:0] held_beat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
    endtask

    // Reference model: an accepted request expands to its word sequence, wrapping at memory end.
    task automatic model_accept(input axi_req_t r);
        int n;
        int w;
        n = (r.len == 8'd0) ? 1 : int'(r.len);
        w = int'(r.addr[MAW+1:2]);
        for (int i = 0; i < n; i++)
            exp_q.push_back({model_mem[(w + i) % MEM_WORDS], r.id, (i == n - 1)});
    endtask

    task automatic clear_trace();
        start_q.delete();
        acc_q.delete();
        last_hs_q.delete();
        id_q.delete();
        first_q.delete();
        rr_q.delete();
        n_hs = 0;
        n_valid = 0;
    endtask

    // One clock: sample at the falling edge, score beats, then drive the next inputs.
    task automatic step();
        bit rr;
        @(negedge clk);
        cyc++;
        if (stall_prev) begin
            chk("hold_valid", 64'(RVALID), 64'd1);
            chk("hold_beat", 64'({RDATA, RID, RLAST}), 64'(held_beat));
        end
        if (RVALID && rr_q.size() > 0) rr = rr_q.pop_front();
        else if (rr_rand) rr = ($urandom_range(0, 9) < 7);
        else rr = 1'b1;
        RREADY = rr;
        if (RVALID) n_valid++;
        if (RVALID && !in_burst) begin
            in_burst = 1'b1;
            start_q.push_back(cyc);
            id_q.push_back(RID);
            first_q.push_back(RDATA);
        end
        if (RVALID && rr) begin
            n_hs++;
            if (exp_q.size() == 0) fail("extra_beat");
            else chk("beat", 64'({RDATA, RID, RLAST}), 64'(exp_q.pop_front()));
            if (RLAST) begin
                in_burst = 1'b0;
                last_hs_q.push_back(cyc);
            end
        end
        stall_prev = RVALID && !rr;
        held_beat  = {RDATA, RID, RLAST};
        if (req_q.size() > 0 && (!ar_rand || ARVALID || $urandom_range(0, 2) != 0)) begin
            ARVALID = 1'b1;
            ARADDR  = req_q[0].addr;
            ARLEN   = req_q[0].len;
            ARID    = req_q[0].id;
            if (ARREADY) begin
                model_accept(req_q.pop_front());
                acc_q.push_back(cyc);
            end else begin
                ar_stall_seen = 1'b1;
            end
        end else begin
            ARVALID = 1'b0;
        end
    endtask

    task automatic run_idle(input int bound, input string name);
        int k;
        k = 0;
        while ((req_q.size() != 0 || exp_q.size() != 0) && k < bound) begin
            step();
            k++;
        end
        if (req_q.size() != 0 || exp_q.size() != 0) begin
            fail(name);
            exp_q.delete();
            req_q.delete();
        end
        step();
        step();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [DATA_WIDTH-1:0] d;
        axi_req_t r;

        vecs[0] = '{addr: 32'h0000_0040, len: 8'd4, id: 4'd3,  rr_pat: 8'h00, rr_n: 0, exp_beats: 4, exp_word: 'h010};
        vecs[1] = '{addr: 32'h0000_0040, len: 8'd4, id: 4'd3,  rr_pat: 8'h59, rr_n: 7, exp_beats: 4, exp_word: 'h010};
        vecs[2] = '{addr: 32'h0000_3FFC, len: 8'd2, id: 4'd5,  rr_pat: 8'h00, rr_n: 0, exp_beats: 2, exp_word: 'hFFF};
        vecs[3] = '{addr: 32'h0000_0044, len: 8'd0, id: 4'd7,  rr_pat: 8'h00, rr_n: 0, exp_beats: 1, exp_word: 'h011};
        vecs[4] = '{addr: 32'h0001_0048, len: 8'd3, id: 4'd9,  rr_pat: 8'h05, rr_n: 3, exp_beats: 3, exp_word: 'h012};
        vecs[5] = '{addr: 32'h0000_0043, len: 8'd2, id: 4'hF,  rr_pat: 8'h00, rr_n: 0, exp_beats: 2, exp_word: 'h010};

        rst_n = 1'b0;
        ARVALID = 1'b0;
        ARADDR = '0;
        ARLEN = '0;
        ARID = '0;
        RREADY = 1'b0;
        i_load_we = 1'b0;
        i_load_addr = '0;
        i_load_data = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_arready", 64'(ARREADY), 64'd0);
        chk("reset_rvalid", 64'(RVALID), 64'd0);
        chk("reset_rlast", 64'(RLAST), 64'd0);
        chk("reset_rid", 64'(RID), 64'd0);
        chk("reset_rdata", 64'(RDATA), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_arready", 64'(ARREADY), 64'd1);

        // Backdoor preload: words 0x10..0x13 = A0..A3, everything else random
        for (int a = 0; a < MEM_WORDS; a++) begin
            d = (a >= 'h10 && a <= 'h13) ? 32'(32'hA0 + (a - 'h10)) : $urandom();
            model_mem[a] = d;
            i_load_we = 1'b1;
            i_load_addr = 12'(a);
            i_load_data = d;
            @(negedge clk);
        end
        i_load_we = 1'b0;

        // Table-driven single bursts
        for (int v = 0; v < 6; v++) begin
            clear_trace();
            for (int b = 0; b < vecs[v].rr_n; b++) rr_q.push_back(vecs[v].rr_pat[b]);
            r = '{addr: vecs[v].addr, len: vecs[v].len, id: vecs[v].id};
            req_q.push_back(r);
            run_idle(200, "vec_timeout");
            chk("vec_beats", 64'(n_hs), 64'(vecs[v].exp_beats));
            if (start_q.size() > 0 && acc_q.size() > 0) begin
                chk("vec_latency", 64'(start_q[0] - acc_q[0]), 64'(LAT + 1));
                chk("vec_first_data", 64'(first_q[0]), 64'(model_mem[vecs[v].exp_word]));
                chk("vec_rid", 64'(id_q[0]), 64'(vecs[v].id));
            end else begin
                fail("vec_no_burst");
            end
        end

        // Back-to-back requests: queue fills, order kept, no idle bubble between bursts
        clear_trace();
        ar_stall_seen = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            r = '{addr: 32'(i * 64), len: 8'd2, id: 4'(i)};
            req_q.push_back(r);
        end
        run_idle(300, "b2b_timeout");
        chk("b2b_arready_drop", 64'(ar_stall_seen), 64'd1);
        chk("b2b_bursts", 64'(id_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < id_q.size()) chk("b2b_order", 64'(id_q[i]), 64'(i + 1));
        if (start_q.size() >= 2 && last_hs_q.size() >= 1)
            chk("b2b_gap", 64'(start_q[1] - last_hs_q[0]), 64'(LAT + 1));
        else
            fail("b2b_gap_missing");

        // Reset in the middle of a burst with a second request queued
        clear_trace();
        r = '{addr: 32'h40, len: 8'd4, id: 4'd6};
        req_q.push_back(r);
        r = '{addr: 32'h80, len: 8'd3, id: 4'd8};
        req_q.push_back(r);
        k = 0;
        while (n_hs < 2 && k < 100) begin
            step();
            k++;
        end
        if (n_hs < 2) fail("midrst_timeout");
        rst_n = 1'b0;
        ARVALID = 1'b0;
        RREADY = 1'b1;
        exp_q.delete();
        req_q.delete();
        in_burst = 1'b0;
        stall_prev = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid", 64'(RVALID), 64'd0);
        chk("midrst_arready", 64'(ARREADY), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_release_arready", 64'(ARREADY), 64'd1);
        clear_trace();
        repeat (12) step();
        chk("midrst_no_stale", 64'(n_valid), 64'd0);
        r = '{addr: 32'h44, len: 8'd2, id: 4'hA};
        req_q.push_back(r);
        run_idle(100, "midrst_new_timeout");
        chk("midrst_new_beats", 64'(n_hs), 64'd2);

        // Randomized traffic with back-pressure and gaps
        clear_trace();
        rr_rand = 1'b1;
        ar_rand = 1'b1;
        total_beats = 0;
        for (int i = 0; i < 200; i++) begin
            r.addr = $urandom();
            if ($urandom_range(0, 3) == 0) r.addr[13:2] = 12'(MEM_WORDS - 1 - $urandom_range(0, 3));
            r.len = 8'($urandom_range(0, 6));
            r.id = 4'($urandom_range(0, 15));
            total_beats += (r.len == 8'd0) ? 1 : int'(r.len);
            req_q.push_back(r);
        end
        run_idle(20000, "rand_timeout");
        chk("rand_bursts", 64'(id_q.size()), 64'd200);
        chk("rand_beats", 64'(n_hs), 64'(total_beats));
        chk("rand_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
